// File: rtl/config_pkg.sv
// Build-wide configuration constants for the data-memory subsystem.
package config_pkg;

  localparam int DMemAddrWidth  = 12;
  localparam int DMemArbMaxWait = 4;

endpackage

// File: rtl/mem_pkg.sv
// Shared data-memory types: access width and the dmem arbiter FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the core and an external requester.
// The core wins by default; an external access deferred MaxWait cycles stalls the core.
module dmem_arbiter
  import config_pkg::*;
  import mem_pkg::*;
#(
  parameter int MaxWait = DMemArbMaxWait
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     core_req,
  input  logic                     core_we,
  input  logic                     core_sign_extend,
  input  mem_width_t               core_width,
  input  logic [DMemAddrWidth-1:0] core_addr,
  input  logic [31:0]              core_wdata,
  input  logic                     ext_req,
  input  logic                     ext_we,
  input  mem_width_t               ext_width,
  input  logic [DMemAddrWidth-1:0] ext_addr,
  input  logic [31:0]              ext_wdata,
  output logic                     ext_ack,
  output logic [31:0]              ext_rdata,
  output logic                     ext_err,
  output logic                     core_stall,
  output logic [31:0]              core_rdata,
  output logic                     core_err,
  output logic                     mem_write_enable,
  output logic                     mem_sign_extend,
  output mem_width_t               mem_width,
  output logic [DMemAddrWidth-1:0] mem_address,
  output logic [31:0]              mem_data_in,
  input  logic [31:0]              mem_data_out,
  input  logic                     mem_alignment_error
);

  // A zero-wait build still needs a one-bit counter to keep the declaration legal.
  localparam int              CntW   = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);

  dmem_arb_state_t state, state_d;
  logic [CntW-1:0] wait_cnt, wait_cnt_d;
  logic [31:0]     ext_rdata_d;
  logic            ext_err_d;
  logic            ext_grant;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      ext_rdata <= '0;
      ext_err   <= 1'b0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_cnt_d;
      ext_rdata <= ext_rdata_d;
      ext_err   <= ext_err_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path leaves a variable unassigned (no latches).
    state_d     = state;
    wait_cnt_d  = wait_cnt;
    ext_rdata_d = ext_rdata;
    ext_err_d   = ext_err;

    ext_grant  = !reset && ext_req && (state != ACK) && (!core_req || wait_cnt == CntMax);
    ext_ack    = !reset && (state == ACK);
    core_stall = core_req && ext_grant;
    core_rdata = mem_data_out;
    core_err   = mem_alignment_error;

    if (ext_grant) begin
      mem_sign_extend = 1'b0;
      mem_width       = ext_width;
      mem_address     = ext_addr;
      mem_data_in     = ext_wdata;
    end else begin
      mem_sign_extend = core_sign_extend;
      mem_width       = core_width;
      mem_address     = core_addr;
      mem_data_in     = core_wdata;
    end
    // Reset must never let a core store through, even though grant is already off.
    mem_write_enable = !reset && (ext_grant ? ext_we : (core_req && core_we));

    case (state)
      ACK: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        if (ext_grant) begin
          state_d     = ACK;
          ext_rdata_d = mem_data_out;
          ext_err_d   = mem_alignment_error;
        end else if (ext_req) begin
          state_d = WAIT;
          if (wait_cnt != CntMax) wait_cnt_d = wait_cnt + CntW'(1);
        end else begin
          // A request withdrawn while waiting is simply forgotten.
          state_d    = IDLE;
          wait_cnt_d = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural dmem behind the port.
// A second instance with MaxWait = 0 checks the external-priority build.
module tb_dmem_arbiter;
  import config_pkg::*;
  import mem_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     core_req, core_we, core_sign_extend;
  mem_width_t               core_width;
  logic [DMemAddrWidth-1:0] core_addr;
  logic [31:0]              core_wdata;
  logic                     ext_req, ext_we;
  mem_width_t               ext_width;
  logic [DMemAddrWidth-1:0] ext_addr;
  logic [31:0]              ext_wdata;
  logic                     ext_ack, ext_err, core_stall, core_err;
  logic [31:0]              ext_rdata, core_rdata;
  logic                     mem_write_enable, mem_sign_extend;
  mem_width_t               mem_width;
  logic [DMemAddrWidth-1:0] mem_address;
  logic [31:0]              mem_data_in, mem_data_out;
  logic                     mem_alignment_error;

  logic                     ack0, err0, stall0, cerr0, mwe0, msx0;
  logic [31:0]              rdata0, crdata0, mdin0;
  mem_width_t               mwidth0;
  logic [DMemAddrWidth-1:0] maddr0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_sign_extend(core_sign_extend),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_width(ext_width),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ext_err(ext_err),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_err(core_err),
    .mem_write_enable(mem_write_enable), .mem_sign_extend(mem_sign_extend),
    .mem_width(mem_width), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_alignment_error(mem_alignment_error)
  );

  dmem_arbiter #(.MaxWait(0)) dut0 (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_sign_extend(core_sign_extend),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_width(ext_width),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ack0), .ext_rdata(rdata0), .ext_err(err0),
    .core_stall(stall0), .core_rdata(crdata0), .core_err(cerr0),
    .mem_write_enable(mwe0), .mem_sign_extend(msx0),
    .mem_width(mwidth0), .mem_address(maddr0), .mem_data_in(mdin0),
    .mem_data_out(32'h0), .mem_alignment_error(1'b0)
  );

  // Behavioural dmem: 32 words, combinational read, write on the clock edge.
  logic [31:0] tb_mem [0:31];
  logic [31:0] rd_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic        tb_misaligned;

  always_comb begin
    rd_word       = tb_mem[mem_address[6:2]];
    rd_half       = mem_address[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte       = rd_word[8*mem_address[1:0] +: 8];
    tb_misaligned = (mem_width == MEM_HALF && mem_address[0]) ||
                    (mem_width == MEM_WORD && mem_address[1:0] != 2'b00);
    case (mem_width)
      MEM_BYTE: mem_data_out = mem_sign_extend ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      MEM_HALF: mem_data_out = mem_sign_extend ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default:  mem_data_out = rd_word;
    endcase
    mem_alignment_error = tb_misaligned;
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= '0;
      tb_mem[8]  <= 32'h12345678;
      tb_mem[12] <= 32'hCAFEF00D;
    end else if (mem_write_enable && !tb_misaligned) begin
      case (mem_width)
        MEM_BYTE: tb_mem[mem_address[6:2]][8*mem_address[1:0] +: 8] <= mem_data_in[7:0];
        MEM_HALF: tb_mem[mem_address[6:2]][16*mem_address[1] +: 16] <= mem_data_in[15:0];
        default:  tb_mem[mem_address[6:2]] <= mem_data_in;
      endcase
    end
  end

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_sign_extend = 1'b0;
    core_width = MEM_WORD; core_addr = 12'h010; core_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_width = MEM_WORD;
    ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %0h exp 0", ext_ack); end
    n_tests++; if (ext_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", ext_rdata); end
    n_tests++; if (ext_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0h exp 0", ext_err); end
    core_req = 1'b1; core_we = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
    #1;
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0h exp 0", core_stall); end
    n_tests++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0h exp 0", mem_write_enable); end
    n_tests++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL rst_stall0: got %0h exp 0", stall0); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack_held: got %0h exp 0", ext_ack); end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_ext_write();
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b1; ext_width = MEM_WORD; ext_addr = 12'h010; ext_wdata = 32'hDEADBEEF;
    #1;
    n_tests++; if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %0h exp 1", mem_write_enable); end
    n_tests++; if (mem_address !== 12'h010) begin n_fail++; $display("FAIL wr_addr: got %h exp 010", mem_address); end
    n_tests++; if (mem_data_in !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data: got %h exp deadbeef", mem_data_in); end
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL wr_stall: got %0h exp 0", core_stall); end
    n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_early: got %0h exp 0", ext_ack); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %0h exp 1", ext_ack); end
    n_tests++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL wr_we_in_ack: got %0h exp 0", mem_write_enable); end
    ext_req = 1'b0; ext_we = 1'b0;
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 12'h010;
    #1;
    n_tests++; if (core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_readback: got %h exp deadbeef", core_rdata); end
    n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %0h exp 0", ext_ack); end
    idle_inputs();
  endtask

  task automatic test_core_contention();
    @(negedge clk);
    core_req = 1'b1; core_addr = 12'h010;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'h030;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL cont_defer_stall cyc %0d: got %0h exp 0", c, core_stall); end
      n_tests++; if (mem_address !== 12'h010) begin n_fail++; $display("FAIL cont_defer_addr cyc %0d: got %h exp 010", c, mem_address); end
      @(negedge clk);
    end
    #1;
    n_tests++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL cont_grant_stall: got %0h exp 1", core_stall); end
    n_tests++; if (mem_address !== 12'h030) begin n_fail++; $display("FAIL cont_grant_addr: got %h exp 030", mem_address); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b1) begin n_fail++; $display("FAIL cont_ack: got %0h exp 1", ext_ack); end
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL cont_ack_stall: got %0h exp 0", core_stall); end
    n_tests++; if (ext_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL cont_rdata: got %h exp cafef00d", ext_rdata); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    core_addr = 12'h010;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'h020;
    #1;
    n_tests++; if (mem_address !== 12'h020) begin n_fail++; $display("FAIL b2b_grant1: got %h exp 020", mem_address); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1: got %0h exp 1", ext_ack); end
    n_tests++; if (ext_rdata !== 32'h12345678) begin n_fail++; $display("FAIL b2b_rdata: got %h exp 12345678", ext_rdata); end
    n_tests++; if (ext_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %0h exp 0", ext_err); end
    n_tests++; if (mem_address !== 12'h010) begin n_fail++; $display("FAIL b2b_no_grant_in_ack: got %h exp 010", mem_address); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_pulse: got %0h exp 0", ext_ack); end
    n_tests++; if (mem_address !== 12'h020) begin n_fail++; $display("FAIL b2b_grant2: got %h exp 020", mem_address); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2: got %0h exp 1", ext_ack); end
    idle_inputs();
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack2_pulse: got %0h exp 0", ext_ack); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b0; ext_width = MEM_HALF; ext_addr = 12'h021; ext_wdata = 32'hFFFFFFFF;
    #1;
    n_tests++; if (mem_address !== 12'h021) begin n_fail++; $display("FAIL mis_addr: got %h exp 021", mem_address); end
    n_tests++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL mis_we: got %0h exp 0", mem_write_enable); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b1) begin n_fail++; $display("FAIL mis_ack: got %0h exp 1", ext_ack); end
    n_tests++; if (ext_err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %0h exp 1", ext_err); end
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    core_req = 1'b1; core_addr = 12'h010;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'h020;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rw_stall_in_rst: got %0h exp 0", core_stall); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rw_defer_stall cyc %0d: got %0h exp 0", c, core_stall); end
      n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL rw_no_ack cyc %0d: got %0h exp 0", c, ext_ack); end
      @(negedge clk);
    end
    #1;
    n_tests++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL rw_grant_stall: got %0h exp 1", core_stall); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b1) begin n_fail++; $display("FAIL rw_ack: got %0h exp 1", ext_ack); end
    n_tests++; if (ext_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rw_rdata: got %h exp 12345678", ext_rdata); end
    idle_inputs();
  endtask

  task automatic test_drop_in_wait();
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b1; core_addr = 12'h040; core_wdata = 32'h0BADF00D;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'h044; ext_wdata = 32'h11111111;
    #1;
    n_tests++; if (mem_address !== 12'h040) begin n_fail++; $display("FAIL drop_core_addr: got %h exp 040", mem_address); end
    n_tests++; if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL drop_core_we: got %0h exp 1", mem_write_enable); end
    @(negedge clk);
    ext_req = 1'b0; core_addr = 12'h048; core_wdata = 32'h22222222;
    #1;
    n_tests++; if (mem_address !== 12'h048) begin n_fail++; $display("FAIL drop_core_addr2: got %h exp 048", mem_address); end
    n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL drop_no_ack1: got %0h exp 0", ext_ack); end
    @(negedge clk);
    core_we = 1'b0; core_addr = 12'h040;
    #1;
    n_tests++; if (ext_ack !== 1'b0) begin n_fail++; $display("FAIL drop_no_ack2: got %0h exp 0", ext_ack); end
    n_tests++; if (tb_mem[16] !== 32'h0BADF00D) begin n_fail++; $display("FAIL drop_store1: got %h exp 0badf00d", tb_mem[16]); end
    n_tests++; if (tb_mem[18] !== 32'h22222222) begin n_fail++; $display("FAIL drop_store2: got %h exp 22222222", tb_mem[18]); end
    n_tests++; if (tb_mem[17] !== 32'h0) begin n_fail++; $display("FAIL drop_no_ext_write: got %h exp 0", tb_mem[17]); end
    // A fresh request must again be deferred the full four cycles.
    ext_req = 1'b1; ext_we = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL drop_redefer cyc %0d: got %0h exp 0", c, core_stall); end
      @(negedge clk);
    end
    #1;
    n_tests++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL drop_regrant: got %0h exp 1", core_stall); end
    @(negedge clk); #1;
    n_tests++; if (ext_ack !== 1'b1) begin n_fail++; $display("FAIL drop_reack: got %0h exp 1", ext_ack); end
    idle_inputs();
  endtask

  task automatic test_maxwait0();
    idle_inputs();
    repeat (2) @(negedge clk);
    core_req = 1'b1; core_addr = 12'h010;
    ext_req = 1'b1; ext_addr = 12'h020;
    #1;
    n_tests++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL mw0_grant: got %0h exp 1", stall0); end
    @(negedge clk); #1;
    n_tests++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL mw0_ack: got %0h exp 1", ack0); end
    n_tests++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL mw0_ack_stall: got %0h exp 0", stall0); end
    @(negedge clk); #1;
    n_tests++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL mw0_regrant: got %0h exp 1", stall0); end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ext_write();
    test_core_contention();
    test_back_to_back();
    test_misaligned();
    test_reset_in_wait();
    test_drop_in_wait();
    test_maxwait0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
